// File: rtl/vga_scan_driver.sv
// VGA raster scan generator: coordinate counters, sync windows and a single pin stage.
// Optional macro VGA_BORDER_EN forces the outermost active ring to FG_COLOUR.
module vga_scan_driver #(
    parameter int unsigned H_ACTIVE  = 1280,
    parameter int unsigned H_FP      = 48,
    parameter int unsigned H_SYNC    = 112,
    parameter int unsigned H_BP      = 248,
    parameter int unsigned V_ACTIVE  = 1024,
    parameter int unsigned V_FP      = 1,
    parameter int unsigned V_SYNC    = 3,
    parameter int unsigned V_BP      = 38,
    parameter logic        SYNC_POL  = 1'b1,
    parameter logic [11:0] FG_COLOUR = 12'hFFF,
    parameter logic [11:0] BG_COLOUR = 12'h000
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [11:0] VGA_horzCoord,
    output logic [11:0] VGA_vertCoord,
    input  logic        PIXEL_ON,
    output logic [11:0] VGA_RGB,
    output logic        VGA_HSYNC,
    output logic        VGA_VSYNC,
    output logic        FRAME_START
);

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned RGB_W   = 12;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
`ifdef VGA_BORDER_EN
    localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
`endif

    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             frame_start_q, frame_start_d;
    logic             active_c;

    // State and pin-stage registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            rgb_q         <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Scan advance: line wrap bumps the row, frame wrap clears both in one step
    always_comb begin
        hcnt_d = hcnt_q + CNT_W'(1);
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            if (vcnt_q == V_LAST) begin
                vcnt_d = '0;
            end else begin
                vcnt_d = vcnt_q + CNT_W'(1);
            end
        end
    end

    // Pin-stage values for the coordinate currently on the counters
    always_comb begin
        active_c      = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        hsync_d       = ~SYNC_POL;
        vsync_d       = ~SYNC_POL;
        rgb_d         = '0;
        frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);

        if ((hcnt_q >= HS_START) && (hcnt_q < HS_END)) begin
            hsync_d = SYNC_POL;
        end
        if ((vcnt_q >= VS_START) && (vcnt_q < VS_END)) begin
            vsync_d = SYNC_POL;
        end

        // PIXEL_ON is only looked at inside the active area, so blanking stays clean
        if (active_c) begin
            if (PIXEL_ON) begin
                rgb_d = FG_COLOUR;
            end else begin
                rgb_d = BG_COLOUR;
            end
`ifdef VGA_BORDER_EN
            if ((hcnt_q == '0) || (hcnt_q == H_ACT_LAST) ||
                (vcnt_q == '0) || (vcnt_q == V_ACT_LAST)) begin
                rgb_d = FG_COLOUR;
            end
`endif
        end
    end

    assign VGA_horzCoord = hcnt_q;
    assign VGA_vertCoord = vcnt_q;
    assign VGA_RGB       = rgb_q;
    assign VGA_HSYNC     = hsync_q;
    assign VGA_VSYNC     = vsync_q;
    assign FRAME_START   = frame_start_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Self-checking bench for vga_scan_driver using a shrunken raster and a frame-index reference model.
module tb_vga_scan_driver;

    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 4;
    localparam int VA  = 8;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int H_T = HA + HFP + HS + HBP;
    localparam int V_T = VA + VFP + VS + VBP;
    localparam int FRAME = H_T * V_T;
    localparam logic        POL = 1'b1;
    localparam logic [11:0] FG  = 12'hFFF;
    localparam logic [11:0] BG  = 12'h05A;

    logic        CLK;
    logic        RESET;
    logic        PIXEL_ON;
    logic [11:0] VGA_horzCoord;
    logic [11:0] VGA_vertCoord;
    logic [11:0] VGA_RGB;
    logic        VGA_HSYNC;
    logic        VGA_VSYNC;
    logic        FRAME_START;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   k        = 0;
    logic last_p   = 1'b0;

    vga_scan_driver #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(POL), .FG_COLOUR(FG), .BG_COLOUR(BG)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .VGA_horzCoord(VGA_horzCoord),
        .VGA_vertCoord(VGA_vertCoord),
        .PIXEL_ON(PIXEL_ON),
        .VGA_RGB(VGA_RGB),
        .VGA_HSYNC(VGA_HSYNC),
        .VGA_VSYNC(VGA_VSYNC),
        .FRAME_START(FRAME_START)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: scan position is just the number of edges since reset, folded into a frame
    function automatic int mh(input int idx);
        return idx % H_T;
    endfunction

    function automatic int mv(input int idx);
        return (idx / H_T) % V_T;
    endfunction

    function automatic bit m_active(input int idx);
        return (mh(idx) < HA) && (mv(idx) < VA);
    endfunction

    function automatic logic [11:0] m_rgb(input int idx, input logic p);
        int h = mh(idx);
        int v = mv(idx);
        if (!m_active(idx)) return 12'h000;
`ifdef VGA_BORDER_EN
        if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) return FG;
`endif
        return (p === 1'b1) ? FG : BG;
    endfunction

    function automatic logic m_hs(input int idx);
        int h = mh(idx);
        return (h >= HA + HFP && h < HA + HFP + HS) ? POL : ~POL;
    endfunction

    function automatic logic m_vs(input int idx);
        int v = mv(idx);
        return (v >= VA + VFP && v < VA + VFP + VS) ? POL : ~POL;
    endfunction

    function automatic logic m_fs(input int idx);
        return (mh(idx) == 0) && (mv(idx) == 0);
    endfunction

    // Random pixel decision; blanking sometimes gets X to prove it never leaks
    function automatic logic rand_p(input int idx);
        if (m_active(idx)) return 1'($urandom_range(0, 1));
        return ($urandom_range(0, 1) == 1) ? 1'bx : 1'b1;
    endfunction

    task automatic tick(input logic p);
        PIXEL_ON = p;
        last_p   = p;
        @(posedge CLK);
        #1;
        k++;
    endtask

    task automatic test_reset;
        RESET    = 1'b1;
        PIXEL_ON = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        n_checks++;
        if (VGA_RGB !== 12'h000) $display("FAIL reset_rgb got %h want 000", VGA_RGB);
        else n_pass++;
        n_checks++;
        if (VGA_HSYNC !== ~POL || VGA_VSYNC !== ~POL)
            $display("FAIL reset_sync got %b%b want %b%b", VGA_HSYNC, VGA_VSYNC, ~POL, ~POL);
        else n_pass++;
        n_checks++;
        if (FRAME_START !== 1'b0) $display("FAIL reset_fs got %b want 0", FRAME_START);
        else n_pass++;
        n_checks++;
        if (VGA_horzCoord !== 12'd0 || VGA_vertCoord !== 12'd0)
            $display("FAIL reset_coord got (%0d,%0d) want (0,0)", VGA_horzCoord, VGA_vertCoord);
        else n_pass++;
        RESET = 1'b0;
        k = 0;
    endtask

    task automatic test_frame_start;
        int pulses = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(1'b0);
            if (FRAME_START === 1'b1) pulses++;
            n_checks++;
            if (FRAME_START !== m_fs(k - 1))
                $display("FAIL frame_start k=%0d got %b want %b", k, FRAME_START, m_fs(k - 1));
            else n_pass++;
        end
        n_checks++;
        if (pulses != 2) $display("FAIL frame_start_count got %0d want 2", pulses);
        else n_pass++;
    endtask

    task automatic test_random_scan;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(rand_p(k));
            n_checks++;
            if (VGA_horzCoord !== 12'(mh(k)) || VGA_vertCoord !== 12'(mv(k)))
                $display("FAIL scan_coord k=%0d got (%0d,%0d) want (%0d,%0d)",
                         k, VGA_horzCoord, VGA_vertCoord, mh(k), mv(k));
            else n_pass++;
            n_checks++;
            if (VGA_RGB !== m_rgb(k - 1, last_p))
                $display("FAIL scan_rgb k=%0d got %h want %h", k, VGA_RGB, m_rgb(k - 1, last_p));
            else n_pass++;
            n_checks++;
            if (VGA_HSYNC !== m_hs(k - 1) || VGA_VSYNC !== m_vs(k - 1))
                $display("FAIL scan_sync k=%0d got %b%b want %b%b",
                         k, VGA_HSYNC, VGA_VSYNC, m_hs(k - 1), m_vs(k - 1));
            else n_pass++;
            n_checks++;
            if (FRAME_START !== m_fs(k - 1))
                $display("FAIL scan_fs k=%0d got %b want %b", k, FRAME_START, m_fs(k - 1));
            else n_pass++;
        end
    endtask

    task automatic test_blanking;
        int fg_cycles = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick(1'b1);
            if (VGA_RGB === FG) fg_cycles++;
            n_checks++;
            if (VGA_RGB !== m_rgb(k - 1, 1'b1))
                $display("FAIL blank_rgb k=%0d got %h want %h", k, VGA_RGB, m_rgb(k - 1, 1'b1));
            else n_pass++;
        end
`ifndef VGA_BORDER_EN
        n_checks++;
        if (fg_cycles != HA * VA) $display("FAIL blank_count got %0d want %0d", fg_cycles, HA * VA);
        else n_pass++;
`endif
    endtask

    task automatic test_sync_timing;
        int   hs_cycles = 0;
        int   vs_cycles = 0;
        logic prev_hs   = VGA_HSYNC;
        for (int i = 0; i < FRAME; i++) begin
            tick(1'b0);
            if (VGA_HSYNC === POL) hs_cycles++;
            if (VGA_VSYNC === POL) vs_cycles++;
            if (VGA_HSYNC === POL && prev_hs === ~POL) begin
                n_checks++;
                if (mh(k - 1) != HA + HFP)
                    $display("FAIL hsync_rise got h=%0d want %0d", mh(k - 1), HA + HFP);
                else n_pass++;
            end
            prev_hs = VGA_HSYNC;
        end
        n_checks++;
        if (hs_cycles != HS * V_T) $display("FAIL hsync_width got %0d want %0d", hs_cycles, HS * V_T);
        else n_pass++;
        n_checks++;
        if (vs_cycles != VS * H_T) $display("FAIL vsync_width got %0d want %0d", vs_cycles, VS * H_T);
        else n_pass++;
    endtask

    task automatic test_mid_reset;
        for (int i = 0; i < FRAME && !(mh(k) == 10 && mv(k) == 5); i++) tick(1'b1);
        tick(1'b1);
        n_checks++;
        if (VGA_RGB !== m_rgb(k - 1, 1'b1))
            $display("FAIL pre_reset_rgb got %h want %h", VGA_RGB, m_rgb(k - 1, 1'b1));
        else n_pass++;
        #2 RESET = 1'b1;
        #1;
        n_checks++;
        if (VGA_RGB !== 12'h000 || VGA_HSYNC !== ~POL || VGA_VSYNC !== ~POL || FRAME_START !== 1'b0)
            $display("FAIL mid_reset_pins got rgb=%h hs=%b vs=%b fs=%b want 000 %b %b 0",
                     VGA_RGB, VGA_HSYNC, VGA_VSYNC, FRAME_START, ~POL, ~POL);
        else n_pass++;
        n_checks++;
        if (VGA_horzCoord !== 12'd0 || VGA_vertCoord !== 12'd0)
            $display("FAIL mid_reset_coord got (%0d,%0d) want (0,0)", VGA_horzCoord, VGA_vertCoord);
        else n_pass++;
        #1 RESET = 1'b0;
        k = 0;
        for (int i = 0; i < 2 * H_T; i++) begin
            tick(rand_p(k));
            n_checks++;
            if (VGA_horzCoord !== 12'(mh(k)) || VGA_vertCoord !== 12'(mv(k)) ||
                FRAME_START !== m_fs(k - 1))
                $display("FAIL restart k=%0d got (%0d,%0d) fs=%b want (%0d,%0d) fs=%b",
                         k, VGA_horzCoord, VGA_vertCoord, FRAME_START, mh(k), mv(k), m_fs(k - 1));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_frame_start();
        test_random_scan();
        test_blanking();
        test_sync_timing();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
